// File: rtl/seq_pattern_generator.sv
// seq_pattern_generator
//   Serial pattern transmitter that drives a 1-bit line. On a start pulse in
//   IDLE it captures pattern/pat_len/rep and shifts the pattern out
//   MSB-first (pattern[pat_len-1] first), one bit per clock, for rep+1
//   passes. After the last bit it emits a one-cycle done pulse.
//
//   Build option: define SEQGEN_GAP_EN to add the gap_len port and a GAP
//   state that inserts gap_len idle cycles between passes. Without it,
//   passes run back-to-back.
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   transfer request, sampled only in IDLE
//   abort      in   synchronous abort, any state
//   pattern    in   [PAT_W] bits to send
//   pat_len    in   [LEN_W] pattern length, legal 1..PAT_W
//   rep        in   [CNT_W] extra passes (total passes = rep+1)
//   gap_len    in   [GAP_W] idle cycles between passes (SEQGEN_GAP_EN only)
//   x          out  serial data, IDLE_LVL when not carrying a bit
//   x_valid    out  high while x carries a pattern bit
//   busy       out  high in SHIFT and GAP
//   done       out  one-cycle pulse after the final bit
//   err        out  one-cycle pulse when start is rejected (bad pat_len)
//   dbg_state  out  current FSM state encoding
//
// Handshake: start is a request with no ready; it is accepted only when the
// FSM is IDLE, abort is low and pat_len is legal. Acceptance is visible as
// busy/x_valid in the following cycle; rejection as an err pulse.

module seq_pattern_generator #(
  parameter int       PAT_W    = 8,
  parameter int       LEN_W    = 4,
  parameter int       CNT_W    = 4,
  parameter logic     IDLE_LVL = 1'b1,
  parameter int       GAP_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] pat_len,
  input  logic [CNT_W-1:0] rep,
`ifdef SEQGEN_GAP_EN
  input  logic [GAP_W-1:0] gap_len,
`endif
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [1:0]       dbg_state
);

  localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
`ifdef SEQGEN_GAP_EN
    , S_GAP = 2'd3
`endif
  } state_t;

  state_t             state_q, state_d;
  logic [PAT_W-1:0]   shadow_q, shadow_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [IDX_W-1:0]   bit_idx_q, bit_idx_d;
  logic [CNT_W-1:0]   rep_cnt_q, rep_cnt_d;
  logic               x_q, x_d;
  logic               x_valid_q, x_valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
`ifdef SEQGEN_GAP_EN
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
`endif

  logic               len_ok;
  logic [IDX_W-1:0]   first_idx;
  logic [IDX_W-1:0]   last_idx;

  assign len_ok    = (pat_len != '0) && (pat_len <= LEN_W'(PAT_W));
  assign first_idx = IDX_W'(pat_len - LEN_W'(1));
  assign last_idx  = IDX_W'(len_q - LEN_W'(1));

  // The registered outputs are computed one cycle ahead: x_d is the bit that
  // will be on the line during the next state, which gives latency 1 from
  // the start-sampling edge to the first bit.
  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    len_d     = len_q;
    bit_idx_d = bit_idx_q;
    rep_cnt_d = rep_cnt_q;
`ifdef SEQGEN_GAP_EN
    gap_d     = gap_q;
    gap_cnt_d = gap_cnt_q;
`endif
    x_d       = IDLE_LVL;
    x_valid_d = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        // abort beats a simultaneous start: the request is simply dropped.
        if (start && !abort) begin
          if (len_ok) begin
            state_d   = S_SHIFT;
            shadow_d  = pattern;
            len_d     = pat_len;
            rep_cnt_d = rep;
            bit_idx_d = first_idx;
`ifdef SEQGEN_GAP_EN
            gap_d     = gap_len;
`endif
            x_d       = pattern[first_idx];
            x_valid_d = 1'b1;
            busy_d    = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      S_SHIFT: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (bit_idx_q != '0) begin
          bit_idx_d = bit_idx_q - IDX_W'(1);
          x_d       = shadow_q[bit_idx_q - IDX_W'(1)];
          x_valid_d = 1'b1;
          busy_d    = 1'b1;
        end else if (rep_cnt_q == '0) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          // End of a pass with passes remaining: reload the bit index.
          rep_cnt_d = rep_cnt_q - CNT_W'(1);
          bit_idx_d = last_idx;
`ifdef SEQGEN_GAP_EN
          if (gap_q != '0) begin
            state_d   = S_GAP;
            gap_cnt_d = gap_q;
            busy_d    = 1'b1;
          end else
`endif
          begin
            x_d       = shadow_q[last_idx];
            x_valid_d = 1'b1;
            busy_d    = 1'b1;
          end
        end
      end

`ifdef SEQGEN_GAP_EN
      // gap_cnt_q counts the idle cycles still to be shown, including this one.
      S_GAP: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (gap_cnt_q == GAP_W'(1)) begin
          state_d   = S_SHIFT;
          x_d       = shadow_q[bit_idx_q];
          x_valid_d = 1'b1;
          busy_d    = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
          busy_d    = 1'b1;
        end
      end
`endif

      S_DONE: begin
        // A start arriving here is deliberately not looked at.
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      shadow_q  <= '0;
      len_q     <= '0;
      bit_idx_q <= '0;
      rep_cnt_q <= '0;
`ifdef SEQGEN_GAP_EN
      gap_q     <= '0;
      gap_cnt_q <= '0;
`endif
      x_q       <= IDLE_LVL;
      x_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      len_q     <= len_d;
      bit_idx_q <= bit_idx_d;
      rep_cnt_q <= rep_cnt_d;
`ifdef SEQGEN_GAP_EN
      gap_q     <= gap_d;
      gap_cnt_q <= gap_cnt_d;
`endif
      x_q       <= x_d;
      x_valid_q <= x_valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign x         = x_q;
  assign x_valid   = x_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_seq_pattern_generator.sv
// Directed testbench for seq_pattern_generator (PAT_W=8, LEN_W=4, CNT_W=4,
// IDLE_LVL=1). Expected serial streams are hand-written bit strings pushed
// into exp_q and consumed one per cycle. Outputs are sampled 1 time unit
// after the rising edge; inputs are driven at the same point.

module tb_seq_pattern_generator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] pattern = '0;
  logic [3:0] pat_len = '0;
  logic [3:0] rep = '0;
`ifdef SEQGEN_GAP_EN
  logic [3:0] gap_len = '0;
`endif
  logic       x;
  logic       x_valid;
  logic       busy;
  logic       done;
  logic       err;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  logic [0:0] exp_q[$];

  seq_pattern_generator dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .pattern   (pattern),
    .pat_len   (pat_len),
    .rep       (rep),
`ifdef SEQGEN_GAP_EN
    .gap_len   (gap_len),
`endif
    .x         (x),
    .x_valid   (x_valid),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) exp_q.push_back(v[i]);
  endtask

  task automatic check_idle(input string tag);
    check({tag, " x"}, 32'(x), 32'd1);
    check({tag, " x_valid"}, 32'(x_valid), 32'd0);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " done"}, 32'(done), 32'd0);
  endtask

  // Start a transfer and compare every cycle against exp_q, then the done
  // pulse and the return to IDLE. With poke set, inputs are scrambled after
  // capture and start is held high through SHIFT and the DONE cycle.
  task automatic run_xfer(input string tag, input logic [7:0] pat,
                          input logic [3:0] len, input logic [3:0] r,
                          input bit poke);
    logic [0:0] b;
    pattern = pat; pat_len = len; rep = r; start = 1'b1;
    tick();
    start = 1'b0;
    if (poke) begin
      pattern = ~pat; pat_len = 4'd2; rep = 4'd9;
    end
    while (exp_q.size() > 0) begin
      b = exp_q.pop_front();
      check({tag, " x"}, 32'(x), 32'(b));
      check({tag, " x_valid"}, 32'(x_valid), 32'd1);
      check({tag, " busy"}, 32'(busy), 32'd1);
      check({tag, " done"}, 32'(done), 32'd0);
      if (poke) start = 1'b1;
      tick();
    end
    check({tag, " done pulse"}, 32'(done), 32'd1);
    check({tag, " done busy"}, 32'(busy), 32'd0);
    check({tag, " done x_valid"}, 32'(x_valid), 32'd0);
    check({tag, " done x"}, 32'(x), 32'd1);
    tick();
    start = 1'b0;
    check_idle({tag, " after"});
    check({tag, " state"}, 32'(dbg_state), 32'd0);
    tick();
    check_idle({tag, " after2"});
  endtask

  initial begin
    // reset values
    #12;
    check_idle("reset");
    check("reset err", 32'(err), 32'd0);
    check("reset state", 32'(dbg_state), 32'd0);
    rst_n = 1'b1;
    tick();

    // test 1: 0101 once, done in cycle 5
    push_bits(32'b0101, 4);
    run_xfer("t1", 8'h05, 4'd4, 4'd0, 1'b0);

    // test 2: 0110 x3, no bubble, done in cycle 13
    push_bits(32'b0110_0110_0110, 12);
    run_xfer("t2", 8'h06, 4'd4, 4'd2, 1'b0);

    // boundary: pat_len=PAT_W, rep=max -> 16 full passes
    for (int i = 0; i < 16; i++) push_bits(32'b1001_0110, 8);
    run_xfer("full", 8'h96, 4'd8, 4'd15, 1'b0);

    // boundary: pat_len=1
    push_bits(32'b1, 1);
    run_xfer("len1", 8'hFD, 4'd1, 4'd0, 1'b0);

    // test 3: illegal lengths
    pattern = 8'h05; rep = 4'd0; pat_len = 4'd0; start = 1'b1;
    tick();
    start = 1'b0;
    check("len0 err", 32'(err), 32'd1);
    check_idle("len0");
    tick();
    check("len0 err end", 32'(err), 32'd0);
    pat_len = 4'd9; start = 1'b1;
    tick();
    start = 1'b0;
    check("len9 err", 32'(err), 32'd1);
    check_idle("len9");
    tick();
    check("len9 err end", 32'(err), 32'd0);
    check("len9 state", 32'(dbg_state), 32'd0);

    // test 4: abort in cycle 3
    pattern = 8'h05; pat_len = 4'd4; rep = 4'd0; start = 1'b1;
    tick();
    start = 1'b0;
    check("abort c1 x", 32'(x), 32'd0);
    tick();
    check("abort c2 x", 32'(x), 32'd1);
    tick();
    check("abort c3 x", 32'(x), 32'd0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_idle("abort c4");
    check("abort c4 state", 32'(dbg_state), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_idle("abort later");
    end

    // start + abort together in IDLE
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check_idle("start+abort");
    check("start+abort err", 32'(err), 32'd0);
    tick();
    check_idle("start+abort 2");

    // test 5: start held during SHIFT and DONE, inputs changed after capture
    push_bits(32'b0101, 4);
    run_xfer("t5", 8'h05, 4'd4, 4'd0, 1'b1);
    check("t5 err", 32'(err), 32'd0);

    // async reset mid-transfer
    pattern = 8'h05; pat_len = 4'd4; rep = 4'd3; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("rst pre busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_idle("rst async");
    check("rst async state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_idle("rst after");
    end

`ifdef SEQGEN_GAP_EN
    // test 6: gaps between passes
    begin
      logic [10:0] exp_v, exp_x;
      exp_v = 11'b1111_000_1111;
      exp_x = 11'b0101_111_0101;
      pattern = 8'h05; pat_len = 4'd4; rep = 4'd1; gap_len = 4'd3; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 10; i >= 0; i--) begin
        check("gap x", 32'(x), 32'(exp_x[i]));
        check("gap x_valid", 32'(x_valid), 32'(exp_v[i]));
        check("gap busy", 32'(busy), 32'd1);
        check("gap done", 32'(done), 32'd0);
        tick();
      end
      check("gap done pulse", 32'(done), 32'd1);
      tick();
      check_idle("gap after");
      gap_len = 4'd0;
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
